// File: rtl/ps2_kb_pkg.sv
// Shared types and constants for the PS/2 keyboard path: prefix state,
// set-2 framing bytes and the pass-through control codes.
package ps2_kb_pkg;

    typedef enum logic {
        IDLE,
        BREAK
    } pfx_state_t;

    localparam logic [7:0] PS2_BREAK    = 8'hF0;
    localparam logic [7:0] PS2_EXT0     = 8'hE0;
    localparam logic [7:0] PS2_EXT1     = 8'hE1;
    localparam logic [7:0] PS2_OVR_LO   = 8'h00;
    localparam logic [7:0] PS2_OVR_HI   = 8'hFF;
    localparam logic [7:0] XT_OVERRUN   = 8'hFF;
    localparam logic [7:0] XT_BREAK_BIT = 8'h80;

    localparam int unsigned N_CTRL_CODES = 6;
    localparam logic [7:0] CTRL_CODES [N_CTRL_CODES] =
        '{8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE};

    function automatic logic is_ctrl_code(input logic [7:0] c);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_CTRL_CODES; i++) begin
            if (c == CTRL_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_set2_to_set1_rom.sv
// Combinational set-2 to set-1 make-code map; unmapped codes give 0x00.
module ps2_set2_to_set1_rom (
    input  logic [7:0] set2,
    output logic [7:0] set1
);

    always_comb begin
        set1 = 8'h00;
        unique case (set2)
            8'h01: set1 = 8'h43;  8'h03: set1 = 8'h3F;  8'h04: set1 = 8'h3D;
            8'h05: set1 = 8'h3B;  8'h06: set1 = 8'h3C;  8'h07: set1 = 8'h58;
            8'h09: set1 = 8'h44;  8'h0A: set1 = 8'h42;  8'h0B: set1 = 8'h40;
            8'h0C: set1 = 8'h3E;  8'h0D: set1 = 8'h0F;  8'h0E: set1 = 8'h29;
            8'h11: set1 = 8'h38;  8'h12: set1 = 8'h2A;  8'h14: set1 = 8'h1D;
            8'h15: set1 = 8'h10;  8'h16: set1 = 8'h02;  8'h1A: set1 = 8'h2C;
            8'h1B: set1 = 8'h1F;  8'h1C: set1 = 8'h1E;  8'h1D: set1 = 8'h11;
            8'h1E: set1 = 8'h03;  8'h21: set1 = 8'h2E;  8'h22: set1 = 8'h2D;
            8'h23: set1 = 8'h20;  8'h24: set1 = 8'h12;  8'h25: set1 = 8'h05;
            8'h26: set1 = 8'h04;  8'h29: set1 = 8'h39;  8'h2A: set1 = 8'h2F;
            8'h2B: set1 = 8'h21;  8'h2C: set1 = 8'h14;  8'h2D: set1 = 8'h13;
            8'h2E: set1 = 8'h06;  8'h31: set1 = 8'h31;  8'h32: set1 = 8'h30;
            8'h33: set1 = 8'h23;  8'h34: set1 = 8'h22;  8'h35: set1 = 8'h15;
            8'h36: set1 = 8'h07;  8'h3A: set1 = 8'h32;  8'h3B: set1 = 8'h24;
            8'h3C: set1 = 8'h16;  8'h3D: set1 = 8'h08;  8'h3E: set1 = 8'h09;
            8'h41: set1 = 8'h33;  8'h42: set1 = 8'h25;  8'h43: set1 = 8'h17;
            8'h44: set1 = 8'h18;  8'h45: set1 = 8'h0B;  8'h46: set1 = 8'h0A;
            8'h49: set1 = 8'h34;  8'h4A: set1 = 8'h35;  8'h4B: set1 = 8'h26;
            8'h4C: set1 = 8'h27;  8'h4D: set1 = 8'h19;  8'h4E: set1 = 8'h0C;
            8'h52: set1 = 8'h28;  8'h54: set1 = 8'h1A;  8'h55: set1 = 8'h0D;
            8'h58: set1 = 8'h3A;  8'h59: set1 = 8'h36;  8'h5A: set1 = 8'h1C;
            8'h5B: set1 = 8'h1B;  8'h5D: set1 = 8'h2B;  8'h61: set1 = 8'h56;
            8'h66: set1 = 8'h0E;  8'h69: set1 = 8'h4F;  8'h6B: set1 = 8'h4B;
            8'h6C: set1 = 8'h47;  8'h70: set1 = 8'h52;  8'h71: set1 = 8'h53;
            8'h72: set1 = 8'h50;  8'h73: set1 = 8'h4C;  8'h74: set1 = 8'h4D;
            8'h75: set1 = 8'h48;  8'h76: set1 = 8'h01;  8'h77: set1 = 8'h45;
            8'h78: set1 = 8'h57;  8'h79: set1 = 8'h4E;  8'h7A: set1 = 8'h51;
            8'h7B: set1 = 8'h4A;  8'h7C: set1 = 8'h37;  8'h7D: set1 = 8'h49;
            8'h7E: set1 = 8'h46;  8'h83: set1 = 8'h41;  8'h84: set1 = 8'h54;
            default: set1 = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_translator.sv
// Translates set-2 PS/2 bytes into XT set-1 codes and queues them in a small
// FIFO for the host side, with a level IRQ and a sticky overflow flag.
module ps2_scancode_translator
    import ps2_kb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       code,
    input  logic             code_valid,
    input  logic             code_error,
    input  logic             clear,
    input  logic             read,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             irq,
    output logic             overflow,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    pfx_state_t       pfx_q, pfx_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             irq_q, irq_d;

    logic [7:0] rom_out;
    logic       push;
    logic [7:0] push_data;
    logic       do_pop;
    logic       full;
    logic       accept;

    ps2_set2_to_set1_rom u_rom (
        .set2 (code),
        .set1 (rom_out)
    );

    always_comb begin
        pfx_d     = pfx_q;
        push      = 1'b0;
        push_data = 8'h00;
        if (code_error) begin
            pfx_d = IDLE;
        end else if (code_valid) begin
            unique case (pfx_q)
                IDLE: begin
                    if (code == PS2_BREAK) begin
                        pfx_d = BREAK;
                    end else if (code == PS2_EXT0 || code == PS2_EXT1 || is_ctrl_code(code)) begin
                        push      = 1'b1;
                        push_data = code;
                    end else if (code == PS2_OVR_LO || code == PS2_OVR_HI) begin
                        push      = 1'b1;
                        push_data = XT_OVERRUN;
                    end else if (rom_out != 8'h00) begin
                        push      = 1'b1;
                        push_data = rom_out;
                    end
                end
                BREAK: begin
                    if (code != PS2_BREAK) begin
                        pfx_d = IDLE;
                        if (rom_out != 8'h00) begin
                            push      = 1'b1;
                            push_data = rom_out | XT_BREAK_BIT;
                        end
                    end
                end
                default: pfx_d = IDLE;
            endcase
        end
    end

    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign do_pop = read && (level_q != '0);
    assign full   = (level_q == FULL_LEVEL);
    assign accept = push && (!full || do_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (push && !accept) overflow_d = 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (accept && !do_pop) level_d = level_q + LVL_ONE;
            else if (!accept && do_pop) level_d = level_q - LVL_ONE;
        end
        irq_d = (level_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pfx_q      <= IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            pfx_q      <= clear ? IDLE : pfx_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign data_valid = (level_q != '0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign irq        = irq_q;
    assign overflow   = overflow_q;
    assign level      = level_q;

endmodule

// File: tb/tb_ps2_scancode_translator.sv
// Scoreboard bench: stimulus queues expected XT bytes, a monitor drains the
// FIFO and compares each head against the queue.
module tb_ps2_scancode_translator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] code = 8'h00;
    logic       code_valid = 1'b0;
    logic       code_error = 1'b0;
    logic       clear = 1'b0;
    logic       stim_read = 1'b0;
    logic       mon_read = 1'b0;
    logic       read;
    logic [7:0] data_out;
    logic       data_valid;
    logic       irq;
    logic       overflow;
    logic [4:0] level;

    int checks = 0;
    int errors = 0;
    logic drain = 1'b0;
    logic [7:0] exp_q [$];

    logic [7:0] ovf_in  [18] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                 8'h45, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
    logic [7:0] ovf_exp [18] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                                 8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    assign read = stim_read | mon_read;

    ps2_scancode_translator #(.FIFO_DEPTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .code       (code),
        .code_valid (code_valid),
        .code_error (code_error),
        .clear      (clear),
        .read       (read),
        .data_out   (data_out),
        .data_valid (data_valid),
        .irq        (irq),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per cycle while draining is enabled.
    always @(negedge clock) begin
        mon_read = 1'b0;
        if (!reset) begin
            check("irq_eq_valid", {31'b0, irq}, {31'b0, data_valid});
            if (!data_valid) begin
                check("empty_data_out", {24'b0, data_out}, 32'h00);
            end else if (drain) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'b0, data_out}, 32'h100);
                end else begin
                    check("fifo_head", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
                end
                mon_read = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] c);
        code = c;
        code_valid = 1'b1;
        @(posedge clock); #1;
        code_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] c, input logic [7:0] e);
        exp_q.push_back(e);
        send(c);
    endtask

    task automatic pulse_error();
        code_error = 1'b1;
        @(posedge clock); #1;
        code_error = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        drain = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (exp_q.size() == 0 && !data_valid) break;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_level_zero"}, {27'b0, level}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_level", {27'b0, level}, 0);
        check("rst_valid", {31'b0, data_valid}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_ovf", {31'b0, overflow}, 0);
        check("rst_data", {24'b0, data_out}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Make code, latency and irq
        drain = 1'b0;
        send(8'h1C);
        check("make_valid", {31'b0, data_valid}, 1);
        check("make_irq", {31'b0, irq}, 1);
        check("make_data", {24'b0, data_out}, 32'h1E);
        check("make_level", {27'b0, level}, 1);
        exp_q.push_back(8'h1E);
        wait_drain("make");

        // Break, extended and pause (back-to-back)
        send(8'hF0); send_exp(8'h1C, 8'h9E);
        send_exp(8'hE0, 8'hE0); send_exp(8'h75, 8'h48);
        send_exp(8'hE0, 8'hE0); send(8'hF0); send_exp(8'h75, 8'hC8);
        send_exp(8'hE1, 8'hE1); send_exp(8'h14, 8'h1D); send_exp(8'h77, 8'h45);
        send_exp(8'hE1, 8'hE1); send(8'hF0); send_exp(8'h14, 8'h9D);
        send(8'hF0); send_exp(8'h77, 8'hC5);
        send_exp(8'h00, 8'hFF); send_exp(8'hAA, 8'hAA); send_exp(8'hFA, 8'hFA);
        send(8'h02);
        send(8'hF0); send(8'hF0); send_exp(8'h76, 8'h81);
        wait_drain("seq");

        // Error cancels pending break
        send(8'hF0);
        pulse_error();
        send_exp(8'h1C, 8'h1E);
        // Error wins over a coincident byte
        code_error = 1'b1;
        send(8'h1C);
        code_error = 1'b0;
        wait_drain("error");

        // Overflow
        drain = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(ovf_exp[i]);
            send(ovf_in[i]);
        end
        check("ovf_level", {27'b0, level}, 16);
        check("ovf_flag", {31'b0, overflow}, 1);
        check("ovf_head", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
        exp_q.push_back(ovf_exp[17]);
        stim_read = 1'b1;
        send(ovf_in[17]);
        stim_read = 1'b0;
        check("full_rw_level", {27'b0, level}, 16);
        check("full_rw_ovf_sticky", {31'b0, overflow}, 1);
        wait_drain("ovf");
        check("ovf_sticky_after_drain", {31'b0, overflow}, 1);

        // Clear flushes FIFO, overflow and prefix
        drain = 1'b0;
        send(8'h1C); send(8'h29); send(8'hF0);
        check("pre_clear_level", {27'b0, level}, 2);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("clear_level", {27'b0, level}, 0);
        check("clear_ovf", {31'b0, overflow}, 0);
        check("clear_valid", {31'b0, data_valid}, 0);
        send_exp(8'h29, 8'h39);
        wait_drain("clear");

        // Async reset mid-stream
        drain = 1'b0;
        send(8'h1C); send(8'h5A); send(8'h76); send(8'hF0);
        check("pre_rst_level", {27'b0, level}, 3);
        #2 reset = 1'b1;
        #1;
        check("arst_level", {27'b0, level}, 0);
        check("arst_valid", {31'b0, data_valid}, 0);
        check("arst_irq", {31'b0, irq}, 0);
        check("arst_ovf", {31'b0, overflow}, 0);
        check("arst_data", {24'b0, data_out}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        send_exp(8'h1C, 8'h1E);
        wait_drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
